// File: rtl/usb_cmd_pkg.sv
// Shared definitions for the PC-link command engine.
// Holds the command opcodes, the FSM state encoding (which is also exported
// on state_out for debug), the FIFO timer selector, and the status-byte tag.
package usb_cmd_pkg;

  localparam logic [3:0] OP_REPORT_PANELS = 4'h1;
  localparam logic [3:0] OP_SET_PANEL     = 4'h2;
  localparam logic [3:0] OP_SET_ROW       = 4'h3;
  localparam logic [3:0] OP_SET_CHUNK     = 4'h4;
  localparam logic [3:0] OP_PUSH_NIBBLE   = 4'h5;
  localparam logic [3:0] OP_COMMIT        = 4'h6;
  localparam logic [3:0] OP_RESET_PTR     = 4'h7;
  localparam logic [3:0] OP_REPORT_STATUS = 4'h8;

  localparam logic [3:0] STATUS_TAG = 4'hF;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_RD_STROBE  = 4'd1,
    ST_EXEC       = 4'd2,
    ST_RD_RECOVER = 4'd3,
    ST_TX_WAIT    = 4'd4,
    ST_TX_SETUP   = 4'd5,
    ST_TX_STROBE  = 4'd6,
    ST_TX_HOLD    = 4'd7
  } state_t;

  typedef enum logic [1:0] {
    TMR_RD,
    TMR_WR,
    TMR_REC
  } timer_sel_t;

  // Error count clipped to the 4 bits that fit in the status byte.
  function automatic logic [3:0] sat_nibble(input logic [7:0] v);
    return (v > 8'd15) ? 4'hF : v[3:0];
  endfunction

endpackage

// File: rtl/usb_fifo_port.sv
// FIFO handshake timer: one down-counter shared by the rd strobe, wr strobe
// and recovery phases (only one is ever active).
// Ports:
//   clk, reset_n - clock and synchronous active-low reset
//   start        - load the counter for the phase chosen by sel
//   sel          - which phase length to load
//   last         - high during the final cycle of the current phase
module usb_fifo_port
  import usb_cmd_pkg::*;
#(
  parameter int RD_PULSE_CYCLES = 4,
  parameter int WR_PULSE_CYCLES = 4,
  parameter int RECOVERY_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  timer_sel_t sel,
  output logic       last
);

  localparam int MAX_A      = (RD_PULSE_CYCLES > WR_PULSE_CYCLES) ? RD_PULSE_CYCLES : WR_PULSE_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > RECOVERY_CYCLES) ? MAX_A : RECOVERY_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  logic [CW-1:0] count_reg;
  logic [CW-1:0] load_next;

  // A phase of N cycles loads N-1 so that 'last' is asserted in its Nth cycle.
  always_comb begin
    load_next = CW'(RECOVERY_CYCLES - 1);
    case (sel)
      TMR_RD:  load_next = CW'(RD_PULSE_CYCLES - 1);
      TMR_WR:  load_next = CW'(WR_PULSE_CYCLES - 1);
      default: load_next = CW'(RECOVERY_CYCLES - 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (start) begin
      count_reg <= load_next;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign last = (count_reg == '0);

endmodule

// File: rtl/usb_command_engine.sv
// PC-link command engine. Runs the FT245-style FIFO read/write handshake,
// decodes 8-bit commands (opcode in [7:4], argument in [3:0]), assembles
// pixel chunks nibble by nibble and sends panel/status reports to the PC.
// Ports:
//   clk, reset_n        - clock and synchronous active-low reset
//   rxf_n, txe_n        - FIFO flags (synchronized)
//   data_bus_in         - FIFO read data (synchronized)
//   panel_switches      - 4-bit ID per panel
//   data_bus_out, data_out_enable, rd_n, wr_n - FIFO write side and strobes
//   panel_addr, row_addr, chunk_addr, chunk_data, chunk_write_enable
//                       - frame-buffer write interface
//   error_count         - saturating count of illegal commands
//   state_out           - FSM state for debug
module usb_command_engine
  import usb_cmd_pkg::*;
#(
  parameter int NUM_PANELS        = 4,
  parameter int ROW_ADDR_WIDTH    = 4,
  parameter int CHUNK_ADDR_WIDTH  = 4,
  parameter int NIBBLES_PER_CHUNK = 8,
  parameter int RD_PULSE_CYCLES   = 4,
  parameter int WR_PULSE_CYCLES   = 4,
  parameter int RECOVERY_CYCLES   = 3,
  localparam int CHUNK_WIDTH      = 4 * NIBBLES_PER_CHUNK,
  localparam int PANEL_AW         = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        rxf_n,
  input  logic                        txe_n,
  input  logic [7:0]                  data_bus_in,
  input  logic [4*NUM_PANELS-1:0]     panel_switches,
  output logic [7:0]                  data_bus_out,
  output logic                        data_out_enable,
  output logic                        rd_n,
  output logic                        wr_n,
  output logic [PANEL_AW-1:0]         panel_addr,
  output logic [ROW_ADDR_WIDTH-1:0]   row_addr,
  output logic [CHUNK_ADDR_WIDTH-1:0] chunk_addr,
  output logic [CHUNK_WIDTH-1:0]      chunk_data,
  output logic                        chunk_write_enable,
  output logic [7:0]                  error_count,
  output logic [3:0]                  state_out
);

  localparam int PTR_W = (NIBBLES_PER_CHUNK > 1) ? $clog2(NIBBLES_PER_CHUNK) : 1;

  state_t                      state_reg;
  logic                        rd_n_reg, wr_n_reg, oe_reg, cwe_reg;
  logic [7:0]                  bus_out_reg, cmd_reg, err_reg;
  logic [PANEL_AW-1:0]         panel_addr_reg, tx_idx_reg;
  logic [ROW_ADDR_WIDTH-1:0]   row_addr_reg;
  logic [CHUNK_ADDR_WIDTH-1:0] chunk_addr_reg;
  logic [PTR_W-1:0]            ptr_reg;
  logic                        report_pending_reg, report_status_reg;

  logic [3:0]              cmd_op, cmd_arg;
  logic                    cmd_illegal, nibble_we, tx_last, timer_start, timer_last;
  timer_sel_t              timer_sel;
  logic [7:0]              tx_byte;
  logic [8*NUM_PANELS-1:0] panel_bytes;

  assign cmd_op  = cmd_reg[7:4];
  assign cmd_arg = cmd_reg[3:0];

  usb_fifo_port #(
    .RD_PULSE_CYCLES (RD_PULSE_CYCLES),
    .WR_PULSE_CYCLES (WR_PULSE_CYCLES),
    .RECOVERY_CYCLES (RECOVERY_CYCLES)
  ) u_fifo_port (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (timer_start),
    .sel     (timer_sel),
    .last    (timer_last)
  );

  // The timer is loaded on the same edge that enters a timed phase.
  always_comb begin
    timer_start = 1'b0;
    timer_sel   = TMR_REC;
    case (state_reg)
      ST_IDLE:      if (!report_pending_reg && !rxf_n) begin
                      timer_start = 1'b1;
                      timer_sel   = TMR_RD;
                    end
      ST_EXEC:      timer_start = 1'b1;
      ST_TX_SETUP:  begin
                      timer_start = 1'b1;
                      timer_sel   = TMR_WR;
                    end
      ST_TX_STROBE: timer_start = timer_last;
      default:      timer_start = 1'b0;
    endcase
  end

  always_comb begin
    cmd_illegal = 1'b1;
    case (cmd_op)
      OP_REPORT_PANELS, OP_PUSH_NIBBLE, OP_COMMIT,
      OP_RESET_PTR, OP_REPORT_STATUS: cmd_illegal = 1'b0;
      OP_SET_PANEL: cmd_illegal = ({28'd0, cmd_arg} >= 32'(NUM_PANELS));
      OP_SET_ROW:   cmd_illegal = ({28'd0, cmd_arg} >= (32'd1 << ROW_ADDR_WIDTH));
      OP_SET_CHUNK: cmd_illegal = ({28'd0, cmd_arg} >= (32'd1 << CHUNK_ADDR_WIDTH));
      default:      cmd_illegal = 1'b1;
    endcase
  end

  assign nibble_we = (state_reg == ST_EXEC) && (cmd_op == OP_PUSH_NIBBLE);

  // Each nibble is its own register; only the one under the pointer updates.
  for (genvar gi = 0; gi < NIBBLES_PER_CHUNK; gi++) begin : g_nibble
    logic [3:0] nibble_reg;
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        nibble_reg <= '0;
      end else if (nibble_we && (ptr_reg == PTR_W'(gi))) begin
        nibble_reg <= cmd_arg;
      end
    end
    assign chunk_data[4*gi +: 4] = nibble_reg;
  end

  for (genvar gi = 0; gi < NUM_PANELS; gi++) begin : g_panel_byte
    assign panel_bytes[8*gi +: 8] = {4'(gi + 1), panel_switches[4*gi +: 4]};
  end

  assign tx_byte = report_status_reg ? {STATUS_TAG, sat_nibble(err_reg)}
                                     : panel_bytes[8*tx_idx_reg +: 8];
  assign tx_last = report_status_reg || (tx_idx_reg == PANEL_AW'(NUM_PANELS - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg          <= ST_IDLE;
      rd_n_reg           <= 1'b1;
      wr_n_reg           <= 1'b1;
      oe_reg             <= 1'b0;
      bus_out_reg        <= '0;
      cmd_reg            <= '0;
      err_reg            <= '0;
      panel_addr_reg     <= '0;
      row_addr_reg       <= '0;
      chunk_addr_reg     <= '0;
      ptr_reg            <= '0;
      cwe_reg            <= 1'b0;
      tx_idx_reg         <= '0;
      report_pending_reg <= 1'b0;
      report_status_reg  <= 1'b0;
    end else begin
      // Commit strobe lasts exactly one cycle; the address advances as it ends.
      cwe_reg <= 1'b0;
      if (cwe_reg) begin
        chunk_addr_reg <= chunk_addr_reg + CHUNK_ADDR_WIDTH'(1);
        ptr_reg        <= '0;
      end
      case (state_reg)
        ST_IDLE: begin
          if (report_pending_reg) begin
            state_reg <= ST_TX_WAIT;
          end else if (!rxf_n) begin
            state_reg <= ST_RD_STROBE;
            rd_n_reg  <= 1'b0;
          end
        end
        ST_RD_STROBE: begin
          if (timer_last) begin
            cmd_reg   <= data_bus_in;
            rd_n_reg  <= 1'b1;
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_reg <= ST_RD_RECOVER;
          if (cmd_illegal) begin
            if (err_reg != 8'hFF) err_reg <= err_reg + 8'd1;
          end else begin
            case (cmd_op)
              OP_REPORT_PANELS, OP_REPORT_STATUS: begin
                report_pending_reg <= 1'b1;
                report_status_reg  <= (cmd_op == OP_REPORT_STATUS);
                tx_idx_reg         <= '0;
              end
              OP_SET_PANEL:   panel_addr_reg <= cmd_arg[PANEL_AW-1:0];
              OP_SET_ROW:     row_addr_reg   <= cmd_arg[ROW_ADDR_WIDTH-1:0];
              OP_SET_CHUNK:   chunk_addr_reg <= cmd_arg[CHUNK_ADDR_WIDTH-1:0];
              OP_PUSH_NIBBLE: ptr_reg <= (ptr_reg == PTR_W'(NIBBLES_PER_CHUNK - 1))
                                         ? '0 : ptr_reg + PTR_W'(1);
              OP_COMMIT:      cwe_reg <= 1'b1;
              OP_RESET_PTR:   ptr_reg <= '0;
              default:        ;
            endcase
          end
        end
        ST_RD_RECOVER: if (timer_last) state_reg <= ST_IDLE;
        ST_TX_WAIT: begin
          if (!txe_n) begin
            state_reg   <= ST_TX_SETUP;
            oe_reg      <= 1'b1;
            bus_out_reg <= tx_byte;
          end
        end
        ST_TX_SETUP: begin
          state_reg <= ST_TX_STROBE;
          wr_n_reg  <= 1'b0;
        end
        ST_TX_STROBE: begin
          if (timer_last) begin
            wr_n_reg  <= 1'b1;
            state_reg <= ST_TX_HOLD;
            // The PC has now received the count, so it starts afresh.
            if (report_status_reg) err_reg <= '0;
          end
        end
        ST_TX_HOLD: begin
          oe_reg <= 1'b0;  // enable was held through the first hold cycle
          if (timer_last) begin
            if (tx_last) begin
              report_pending_reg <= 1'b0;
              state_reg          <= ST_IDLE;
            end else begin
              tx_idx_reg <= tx_idx_reg + PANEL_AW'(1);
              state_reg  <= ST_TX_WAIT;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign data_bus_out       = bus_out_reg;
  assign data_out_enable    = oe_reg;
  assign rd_n               = rd_n_reg;
  assign wr_n               = wr_n_reg;
  assign panel_addr         = panel_addr_reg;
  assign row_addr           = row_addr_reg;
  assign chunk_addr         = chunk_addr_reg;
  assign chunk_write_enable = cwe_reg;
  assign error_count        = err_reg;
  assign state_out          = state_reg;

endmodule

// File: tb/tb_usb_command_engine.sv
// Scoreboard bench for usb_command_engine: commands are fed through a FIFO
// model; expected TX bytes and chunk commits are queued when the command is
// sent and compared when the DUT produces them.
module tb_usb_command_engine;

  localparam int NUM_PANELS = 4;

  logic        clk;
  logic        reset_n;
  logic        rxf_n;
  logic        txe_n;
  logic [7:0]  data_bus_in;
  logic [15:0] panel_switches;
  logic [7:0]  data_bus_out;
  logic        data_out_enable;
  logic        rd_n;
  logic        wr_n;
  logic [1:0]  panel_addr;
  logic [3:0]  row_addr;
  logic [3:0]  chunk_addr;
  logic [31:0] chunk_data;
  logic        chunk_write_enable;
  logic [7:0]  error_count;
  logic [3:0]  state_out;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int tx_seen    = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  tx_exp[$];
  logic [35:0] cmt_exp[$];

  usb_command_engine #(
    .NUM_PANELS        (NUM_PANELS),
    .ROW_ADDR_WIDTH    (4),
    .CHUNK_ADDR_WIDTH  (4),
    .NIBBLES_PER_CHUNK (8),
    .RD_PULSE_CYCLES   (4),
    .WR_PULSE_CYCLES   (4),
    .RECOVERY_CYCLES   (3)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .rxf_n              (rxf_n),
    .txe_n              (txe_n),
    .data_bus_in        (data_bus_in),
    .panel_switches     (panel_switches),
    .data_bus_out       (data_bus_out),
    .data_out_enable    (data_out_enable),
    .rd_n               (rd_n),
    .wr_n               (wr_n),
    .panel_addr         (panel_addr),
    .row_addr           (row_addr),
    .chunk_addr         (chunk_addr),
    .chunk_data         (chunk_data),
    .chunk_write_enable (chunk_write_enable),
    .error_count        (error_count),
    .state_out          (state_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks_cnt++;
    if (observed !== expected) begin
      errors_cnt++;
      $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(rx_q.size() == 0 && tx_exp.size() == 0 && cmt_exp.size() == 0 &&
             state_out == 4'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 64'(n < budget), 1);
  endtask

  // PC-side FIFO: a byte is consumed when rd_n rises.
  initial begin
    logic rd_prev;
    rd_prev     = 1'b1;
    rxf_n       = 1'b1;
    data_bus_in = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_prev === 1'b0 && rd_n === 1'b1 && rx_q.size() > 0) begin
        $display("rx byte %02h consumed", rx_q[0]);
        void'(rx_q.pop_front());
      end
      rd_prev     = rd_n;
      rxf_n       = (rx_q.size() == 0);
      data_bus_in = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end
  end

  // Output monitor: TX bytes on wr_n rise, chunk commits on the strobe.
  initial begin
    logic       wr_prev, cwe_prev;
    logic [7:0] exp_b;
    logic [35:0] exp_c;
    wr_prev  = 1'b1;
    cwe_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && wr_prev === 1'b0 && wr_n === 1'b1) begin
        tx_seen++;
        check("tx_oe_hold", data_out_enable, 1);
        check("tx_expected_pending", 64'(tx_exp.size() != 0), 1);
        if (tx_exp.size() != 0) begin
          exp_b = tx_exp.pop_front();
          $display("tx byte %02h expected %02h", data_bus_out, exp_b);
          check("tx_byte", data_bus_out, exp_b);
        end
      end
      if (chunk_write_enable === 1'b1) begin
        check("cwe_single_cycle", cwe_prev, 0);
        check("commit_expected_pending", 64'(cmt_exp.size() != 0), 1);
        if (cmt_exp.size() != 0) begin
          exp_c = cmt_exp.pop_front();
          $display("commit addr %0h data %08h expected addr %0h data %08h",
                   chunk_addr, chunk_data, exp_c[35:32], exp_c[31:0]);
          check("commit_addr", chunk_addr, exp_c[35:32]);
          check("commit_data", chunk_data, exp_c[31:0]);
        end
      end
      wr_prev  = wr_n;
      cwe_prev = chunk_write_enable;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen_before;
    reset_n        = 1'b0;
    txe_n          = 1'b0;
    panel_switches = 16'h4321;

    // Reset with data waiting in the FIFO.
    send(8'h70);
    repeat (2) @(negedge clk);
    check("rst_rd_n", rd_n, 1);
    check("rst_wr_n", wr_n, 1);
    check("rst_oe", data_out_enable, 0);
    check("rst_bus_out", data_bus_out, 0);
    check("rst_addrs", {panel_addr, row_addr, chunk_addr}, 0);
    check("rst_chunk_data", chunk_data, 0);
    check("rst_cwe", chunk_write_enable, 0);
    check("rst_err", error_count, 0);
    check("rst_state", state_out, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rd_fall_after_release", rd_n, 0);
    check("state_rd_strobe", state_out, 1);
    wait_idle(200);

    // Chunk assembly and commit.
    for (int k = 1; k <= 8; k++) send(8'(8'h50 + k));
    send(8'h60);
    cmt_exp.push_back({4'h0, 32'h87654321});
    wait_idle(400);
    check("chunk_addr_after_commit", chunk_addr, 1);
    check("chunk_data_retained", chunk_data, 32'h87654321);

    // Panel report with a stall before the third byte.
    send(8'h10);
    tx_exp.push_back(8'h11);
    tx_exp.push_back(8'h22);
    tx_exp.push_back(8'h33);
    tx_exp.push_back(8'h44);
    n = 0;
    while (tx_seen < 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("two_bytes_before_stall", 64'(tx_seen), 2);
    txe_n = 1'b1;
    repeat (12) @(negedge clk);
    check("stall_wr_n", wr_n, 1);
    check("stall_state", state_out, 4);
    check("stall_tx_count", 64'(tx_seen), 2);
    txe_n = 1'b0;
    wait_idle(400);

    // Illegal commands and status report.
    send(8'h22);
    send(8'h00);
    send(8'h9A);
    send(8'h25);
    send(8'h3F);
    wait_idle(400);
    check("panel_addr_unchanged", panel_addr, 2);
    check("err_three", error_count, 3);
    check("row_addr_max", row_addr, 15);
    send(8'h80);
    tx_exp.push_back(8'hF3);
    wait_idle(400);
    check("err_cleared", error_count, 0);

    // Error counter saturation.
    for (int k = 0; k < 260; k++) send(8'h00);
    wait_idle(6000);
    check("err_saturated", error_count, 8'hFF);
    check("panel_addr_kept", panel_addr, 2);
    send(8'h80);
    tx_exp.push_back(8'hFF);
    wait_idle(400);
    check("err_cleared_sat", error_count, 0);

    // Nibble pointer wrap and chunk address wrap.
    send(8'h70);
    for (int k = 1; k <= 9; k++) send(8'(8'h50 + k));
    send(8'h4F);
    send(8'h60);
    cmt_exp.push_back({4'hF, 32'h87654329});
    wait_idle(600);
    check("chunk_addr_wrapped", chunk_addr, 0);
    send(8'h5A);
    send(8'h5C);
    send(8'h70);
    send(8'h5B);
    send(8'h60);
    cmt_exp.push_back({4'h0, 32'h876543CB});
    wait_idle(600);
    check("chunk_addr_next", chunk_addr, 1);

    // Reset in the middle of a TX strobe; report must not resume.
    send(8'h10);
    n = 0;
    while (state_out != 4'd6 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reached_tx_strobe", state_out, 6);
    seen_before = tx_seen;
    reset_n = 1'b0;
    @(negedge clk);
    check("midtx_wr_n", wr_n, 1);
    check("midtx_oe", data_out_enable, 0);
    check("midtx_state", state_out, 0);
    check("midtx_chunk_addr", chunk_addr, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_resume_state", state_out, 0);
    check("no_resume_wr_n", wr_n, 1);
    check("no_resume_tx", 64'(tx_seen), 64'(seen_before));

    check("queues_drained", 64'(tx_exp.size() + cmt_exp.size() + rx_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/usb_command_engine.md
Name: usb_command_engine

Overview:
- Parametrised successor to the current PC-link command decoder. Runs the FT245-style FIFO handshake itself (read and write), decodes 8-bit PC commands and assembles pixel chunks.
- Adds an auto-incrementing nibble pointer, chunk-address auto-increment on commit, bounds checking with an error counter, and a status report back to the PC.
- Sits between the input synchronizers and the panel frame buffers.

Parameters:
- NUM_PANELS, 4, number of panels; legal range 1..14; panel_switches carries one 4-bit ID per panel.
- ROW_ADDR_WIDTH, 4, row address width; range 1..4.
- CHUNK_ADDR_WIDTH, 4, chunk address width; range 1..4.
- NIBBLES_PER_CHUNK, 8, nibbles per chunk; range 1..16; CHUNK_WIDTH = 4*NIBBLES_PER_CHUNK.
- RD_PULSE_CYCLES, 4, rd_n low time in cycles; minimum 1.
- WR_PULSE_CYCLES, 4, wr_n low time in cycles; minimum 1.
- RECOVERY_CYCLES, 3, idle cycles after each FIFO access; must be at least synchronizer depth + 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset. One clock; reset is synchronous and active-low.
- rxf_n  in  1  FIFO has data, active low, already synchronized.
- txe_n  in  1  FIFO can accept data, active low, already synchronized.
- data_bus_in  in  8  FIFO read data, already synchronized.
- panel_switches  in  4*NUM_PANELS  panel IDs; panel i occupies [4i+3:4i].
- data_bus_out  out  8  FIFO write data.
- data_out_enable  out  1  bus driver enable.
- rd_n  out  1  FIFO read strobe.
- wr_n  out  1  FIFO write strobe.
- panel_addr  out  max(1,clog2(NUM_PANELS))  selected panel.
- row_addr  out  ROW_ADDR_WIDTH  selected row.
- chunk_addr  out  CHUNK_ADDR_WIDTH  selected chunk.
- chunk_data  out  CHUNK_WIDTH  assembled nibbles; nibble k occupies [4k+3:4k].
- chunk_write_enable  out  1  one-cycle commit strobe.
- error_count  out  8  count of illegal commands, saturating.
- state_out  out  4  FSM state, for debug.

Behaviour:
- Reset values:
  - rd_n = 1, wr_n = 1, data_out_enable = 0, data_bus_out = 0.
  - All addresses, chunk_data, error_count and the nibble pointer = 0; chunk_write_enable = 0.
  - FSM in IDLE; any pending report is dropped.
- Reset applies on the next edge from any state, including mid-strobe.
- FSM states and encodings:
  - IDLE (0): if a report is pending, go to TX_WAIT; else if rxf_n = 0, go to RD_STROBE. Pending report has priority.
  - RD_STROBE (1): rd_n = 0 for RD_PULSE_CYCLES. data_bus_in is latched on the last low cycle. Then go to EXEC.
  - EXEC (2): one cycle, rd_n = 1; decode the latched byte. Then go to RD_RECOVER.
  - RD_RECOVER (3): RECOVERY_CYCLES, then IDLE.
  - TX_WAIT (4): hold until txe_n = 0, then TX_SETUP.
  - TX_SETUP (5): one cycle; data_out_enable = 1, byte driven on data_bus_out.
  - TX_STROBE (6): wr_n = 0 for WR_PULSE_CYCLES.
  - TX_HOLD (7): wr_n = 1, data_out_enable stays 1 for the first cycle, RECOVERY_CYCLES total. Then TX_WAIT if more bytes remain, else IDLE.
- Command decode, opcode = byte[7:4], argument = byte[3:0]:
  - 1: queue panel report of NUM_PANELS bytes, byte i = {i+1, panel_switches[4i+3:4i]}.
  - 2: panel_addr = argument. If argument >= NUM_PANELS: illegal, panel_addr unchanged.
  - 3: row_addr = argument. If argument >= 2^ROW_ADDR_WIDTH: illegal, row_addr unchanged.
  - 4: chunk_addr = argument. Same bound rule with CHUNK_ADDR_WIDTH.
  - 5: store argument into nibble[ptr]; ptr = ptr+1, wrapping NIBBLES_PER_CHUNK-1 -> 0.
  - 6: commit.
    - chunk_write_enable = 1 for exactly the cycle after EXEC, with chunk_data and the pre-increment chunk_addr stable.
    - At the end of that cycle: chunk_addr increments (wraps to 0), ptr resets to 0.
    - chunk_data is retained, not cleared.
  - 7: ptr = 0.
  - 8: queue status byte {4'hF, min(error_count,15)}. error_count clears when this byte's TX_STROBE completes.
  - 0 and 9-15: illegal.
- Illegal command: error_count += 1, saturating at 255; no other state changes.
- Reports are never interleaved with reads. A new report command cannot arrive while a report is pending.

Decomposition:
- Package usb_cmd_pkg holds:
  - opcode constants OP_REPORT_PANELS .. OP_REPORT_STATUS;
  - state enum (4-bit encodings above);
  - STATUS_TAG = 4'hF.
- One natural sub-module: usb_fifo_port, holding the rd/wr strobe timers and recovery counter. Decode and the nibble buffer stay in the top module.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles with rxf_n = 0 -> rd_n = 1, wr_n = 1, data_out_enable = 0, all outputs 0, state_out = 0; first rd_n fall occurs 1 cycle after release.
- Chunk assembly: bytes 51 52 53 54 55 56 57 58 then 60 -> chunk_data = 32'h87654321; chunk_write_enable high for exactly 1 cycle with chunk_addr = 0; chunk_addr = 1 afterwards.
- Panel report: panel_switches = 16'h4321, byte 10 -> TX 11 22 33 44. Holding txe_n = 1 before the third byte keeps wr_n = 1 and state_out = 4 until txe_n = 0.
- Errors and status: bytes 00, 9A, 25 (NUM_PANELS = 4) -> error_count = 3, panel_addr unchanged. Then byte 80 -> TX F3, and error_count = 0 after the strobe.
- Wraps: 9 pushes of 5k -> 9th value lands in nibble 0. Byte 4F then 60 -> commit at chunk_addr 15, then chunk_addr = 0.
- Reset mid-TX: reset_n = 0 during TX_STROBE -> wr_n = 1 and data_out_enable = 0 next cycle; report is not resumed after release.
